pipe_issue: RTL
===============

Name: pipe_issue

Overview:
- Instruction issuer feeding the 4-stage ALU pipeline; it is the initiator that drives rs1/rs2/rd/func/addr into the pipeline.
- Holds a small program RAM, issues one instruction per cycle and detects read-after-write hazards on the register bank.
- On a hazard it inserts a bubble until the producing instruction has reached writeback, then drains and reports completion.

Parameters:
- PROG_DEPTH, 16, program RAM entries (power of 2, max 256).
- PAW, 4, program address width = log2(PROG_DEPTH).
- HAZ_DIST, 3, cycles from issue until rd is written in the regbank (scoreboard depth, 1..4).

Ports:
- clk1  in  1  single clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- prog_we  in  1  program RAM write strobe (honoured only in IDLE).
- prog_waddr  in  PAW  program RAM write address.
- prog_wdata  in  24  instruction word: func[23:20] rd[19:16] rs1[15:12] rs2[11:8] addr[7:0].
- prog_len  in  PAW+1  number of instructions to run (0..PROG_DEPTH), sampled on start.
- start  in  1  begin run at PC 0.
- rs1, rs2, rd, func  out  4 each  issued instruction fields.
- addr  out  8  issued memory address.
- issue_valid  out  1  fields carry a real instruction this cycle; downstream gates regbank/mem writes on it.
- stall  out  1  bubble inserted due to hazard.
- busy  out  1  run in progress (ISSUE or DRAIN).
- done  out  1  one-cycle pulse at end of run.
- issued_cnt  out  8  real instructions issued in current/last run, saturates at 255.

Behaviour:
- Reset: all outputs 0, FSM IDLE, PC 0, scoreboard cleared. Program RAM contents are not reset.
- FSM IDLE:
  - prog_we writes prog_wdata to RAM[prog_waddr].
  - start latches prog_len, clears issued_cnt and PC.
  - start goes to ISSUE if prog_len > 0, otherwise to DONE.
- FSM ISSUE:
  - Each cycle, read RAM[PC] combinationally and evaluate hazard.
  - No hazard: drive fields registered, issue_valid=1, PC++, issued_cnt++.
  - Hazard: all fields 0, issue_valid=0, stall=1, PC holds.
  - After issuing PC = len-1, go to DRAIN.
- FSM DRAIN: HAZ_DIST cycles of issue_valid=0, then DONE.
- FSM DONE: done=1 for one cycle, busy=0, then IDLE.
- Outputs are registered, so there is 1 cycle of latency from PC selection to visible fields.
- Operand use:
  - rs1 is read for func 0,1,2,3,5,6,7,8,10,11.
  - rs2 is read for func 0,1,2,4,5,6,7,9.
- Scoreboard:
  - Shift register of HAZ_DIST entries {valid, rd}, shifted every cycle.
  - Head gets {issue_valid, rd} of the instruction issued this cycle.
  - Hazard = a used source equals rd of any valid entry.
  - The entry falls out exactly when its write lands, so a dependent instruction issues HAZ_DIST cycles after its producer.
- Boundary cases:
  - start while busy: ignored.
  - prog_we outside IDLE: ignored.
  - prog_len > PROG_DEPTH: clamped to PROG_DEPTH.
  - PC wrap: cannot occur because of the clamp.
  - rd == rs1 in the same instruction: no self-hazard.
  - rst_n low mid-run: immediate return to IDLE with all outputs 0; an instruction issued the previous cycle still completes downstream.

Optional Feature:
- Macro ISSUE_HALT_ON_ILLEGAL_EN.
- Defined:
  - func 12..15 is not issued; FSM goes to DRAIN.
  - done pulses after the drain.
  - Sticky output err (1 bit, cleared on start or reset) = 1.
  - issued_cnt excludes the illegal instruction.
- Undefined:
  - func 12..15 is issued normally, treated as using both rs1 and rs2 for hazard checking.
  - No err port.

Test Plan:
- Independent ops: load 4 instrs (func0 R3=R1+R2, func1 R6=R4-R5, func5 R9=R7&R8, func7 R12=R10^R11), prog_len=4, start -> issue_valid high 4 consecutive cycles, stall never 1, done 1+4+3+1 cycles after start, issued_cnt=4.
- RAW hazard: I0 func0 rd=R3, I1 func2 rs1=R3 -> 2 stall cycles (HAZ_DIST=3), I1 issued exactly 3 cycles after I0.
- Operand-use filtering: I0 rd=R5, I1 func4 rs1=R5 rs2=R1 -> no stall (rs1 unused by func4); same case with func3 -> 2 stalls.
- prog_len=0 -> done pulses 1 cycle after start, issue_valid never 1, issued_cnt=0; prog_len=20 with PROG_DEPTH=16 -> exactly 16 instructions issued.
- Reset mid-run: assert rst_n low during ISSUE at PC=2 -> all outputs 0 in same cycle, FSM IDLE; new start after release reruns from PC 0 with program RAM intact.
- ISSUE_HALT_ON_ILLEGAL_EN: instr 1 func=13 in a 3-instr program -> only instr 0 issued, err=1, done pulses after 3 drain cycles, issued_cnt=1.

Source files
------------

// File: rtl/pipe_issue_if.sv
// Issue bus from pipe_issue into the 4-stage ALU pipeline; the issuer is the master.
interface pipe_issue_if;
  logic [3:0] rs1;
  logic [3:0] rs2;
  logic [3:0] rd;
  logic [3:0] func;
  logic [7:0] addr;
  logic       issue_valid;
  logic       stall;

  modport master (output rs1, rs2, rd, func, addr, issue_valid, stall);
  modport slave  (input  rs1, rs2, rd, func, addr, issue_valid, stall);
endinterface

// File: rtl/pipe_issue.sv
// pipe_issue: program-RAM instruction issuer with a RAW scoreboard; fields registered, visible 1 cycle after PC select.
// No downstream backpressure (hazards only stall issue); ISSUE_HALT_ON_ILLEGAL_EN halts the run on func 12..15.
module pipe_issue #(
  parameter int PROG_DEPTH = 16,
  parameter int PAW        = 4,
  parameter int HAZ_DIST   = 3
) (
  input  logic            clk1,
  input  logic            rst_n,
  input  logic            prog_we,
  input  logic [PAW-1:0]  prog_waddr,
  input  logic [23:0]     prog_wdata,
  input  logic [PAW:0]    prog_len,
  input  logic            start,
  pipe_issue_if.master    iss,
  output logic            busy,
  output logic            done,
  output logic [7:0]      issued_cnt
`ifdef ISSUE_HALT_ON_ILLEGAL_EN
  ,
  output logic            err
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int           SBD        = (HAZ_DIST > 1) ? HAZ_DIST - 1 : 1;
  localparam logic [PAW:0] DEPTH_L    = (PAW+1)'(PROG_DEPTH);
  localparam logic [PAW:0] ONE_L      = (PAW+1)'(1);
  localparam logic [2:0]   DRAIN_LAST = 3'(HAZ_DIST);

  logic [23:0]    mem [PROG_DEPTH];
  logic [1:0]     state;
  logic [PAW-1:0] pc;
  logic [PAW:0]   len_q;
  logic [2:0]     drain_cnt;
  logic [SBD-1:0] sb_vld;
  logic [3:0]     sb_rd [SBD];

  logic [3:0] rs1_q, rs2_q, rd_q, func_q;
  logic [7:0] addr_q;
  logic       vld_q, stall_q;

  logic [23:0] instr;
  logic [3:0]  i_func, i_rd, i_rs1, i_rs2;
  logic [7:0]  i_addr;
  logic        use_rs1, use_rs2, hazard, last_pc;

  always_comb begin
    instr   = mem[pc];
    i_func  = instr[23:20];
    i_rd    = instr[19:16];
    i_rs1   = instr[15:12];
    i_rs2   = instr[11:8];
    i_addr  = instr[7:0];
    use_rs1 = i_func inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd10, 4'd11, [4'd12:4'd15]};
    use_rs2 = i_func inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9, [4'd12:4'd15]};
    last_pc = ({1'b0, pc} == (len_q - ONE_L));
    // Oldest tracked producer is HAZ_DIST-1 cycles old; the next cycle its write has landed.
    hazard  = 1'b0;
    for (int i = 0; i < HAZ_DIST - 1; i++) begin
      if (sb_vld[i] && ((use_rs1 && sb_rd[i] == i_rs1) || (use_rs2 && sb_rd[i] == i_rs2)))
        hazard = 1'b1;
    end
  end

  always_ff @(posedge clk1) begin
    if (prog_we && state == S_IDLE)
      mem[prog_waddr] <= prog_wdata;
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= '0;
      len_q      <= '0;
      drain_cnt  <= '0;
      issued_cnt <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      func_q     <= '0;
      addr_q     <= '0;
      vld_q      <= 1'b0;
      stall_q    <= 1'b0;
      sb_vld     <= '0;
      for (int i = 0; i < SBD; i++) sb_rd[i] <= '0;
`ifdef ISSUE_HALT_ON_ILLEGAL_EN
      err        <= 1'b0;
`endif
    end else begin
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      func_q  <= '0;
      addr_q  <= '0;
      vld_q   <= 1'b0;
      stall_q <= 1'b0;
      sb_vld[0] <= 1'b0;
      sb_rd[0]  <= '0;
      for (int i = 1; i < SBD; i++) begin
        sb_vld[i] <= sb_vld[i-1];
        sb_rd[i]  <= sb_rd[i-1];
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            len_q      <= (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
            issued_cnt <= '0;
            pc         <= '0;
`ifdef ISSUE_HALT_ON_ILLEGAL_EN
            err        <= 1'b0;
`endif
            state      <= (prog_len == '0) ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: begin
`ifdef ISSUE_HALT_ON_ILLEGAL_EN
          if (i_func >= 4'd12) begin
            // Output already idle this cycle, so it counts as the first drain cycle.
            err       <= 1'b1;
            drain_cnt <= 3'd1;
            state     <= S_DRAIN;
          end else
`endif
          if (hazard) begin
            stall_q <= 1'b1;
          end else begin
            rs1_q     <= i_rs1;
            rs2_q     <= i_rs2;
            rd_q      <= i_rd;
            func_q    <= i_func;
            addr_q    <= i_addr;
            vld_q     <= 1'b1;
            sb_vld[0] <= 1'b1;
            sb_rd[0]  <= i_rd;
            pc        <= pc + PAW'(1);
            if (issued_cnt != 8'hFF)
              issued_cnt <= issued_cnt + 8'd1;
            if (last_pc) begin
              drain_cnt <= '0;
              state     <= S_DRAIN;
            end
          end
        end
        // Entered while the final issue is visible; HAZ_DIST idle output cycles follow it.
        S_DRAIN: begin
          if (drain_cnt == DRAIN_LAST)
            state <= S_DONE;
          else
            drain_cnt <= drain_cnt + 3'd1;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign iss.rs1         = rs1_q;
  assign iss.rs2         = rs2_q;
  assign iss.rd          = rd_q;
  assign iss.func        = func_q;
  assign iss.addr        = addr_q;
  assign iss.issue_valid = vld_q;
  assign iss.stall       = stall_q;
  assign busy            = (state == S_ISSUE) || (state == S_DRAIN);
  assign done            = (state == S_DONE);

endmodule
